// File: rtl/ram_stream_reader.sv
// ram_stream_reader: reads a block of words from a synchronous-read RAM and
// streams them in address order through a 2-entry FIFO with valid/ready flow control.
`default_nettype none

module ram_stream_reader #(
   parameter int DATA = 8,
   parameter int ADDR = 10
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            abort,
   input  logic [ADDR-1:0] base_addr,
   input  logic [ADDR:0]   length,
   output logic [ADDR-1:0] ram_addr,
   output logic            ram_wr,
   output logic [DATA-1:0] ram_din,
   input  logic [DATA-1:0] ram_dout,
   output logic            out_valid,
   output logic [DATA-1:0] out_data,
   input  logic            out_ready,
   output logic            busy,
   output logic            done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [ADDR-1:0] addr_q, addr_d;
   logic [ADDR:0]   rem_q, rem_d;
   logic [1:0]      occ_q, occ_d;
   logic            inf_q, inf_d;
   logic            rd_ptr_q, rd_ptr_d;
   logic            wr_ptr_q, wr_ptr_d;
   logic            done_q, done_d;
   logic [DATA-1:0] mem_q [2];
   logic            push, pop, issue;
   logic [2:0]      pending;

   always_comb begin
      pop     = (occ_q != 2'd0) && out_ready;
      push    = inf_q && !abort;
      // Slots committed after this cycle's pop: buffered words plus the read in flight.
      pending = {1'b0, occ_q} + {2'b00, inf_q} - {2'b00, pop};
      issue   = (state_q == RUN) && (rem_q != '0) && (pending < 3'd2) && !abort;

      state_d  = state_q;
      addr_d   = addr_q;
      rem_d    = rem_q;
      occ_d    = occ_q + {1'b0, push} - {1'b0, pop};
      inf_d    = issue;
      rd_ptr_d = rd_ptr_q ^ pop;
      wr_ptr_d = wr_ptr_q ^ push;
      done_d   = 1'b0;

      if (issue) begin
         addr_d = addr_q + 1'b1;
         rem_d  = rem_q - 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (start && !abort) begin
               addr_d  = base_addr;
               rem_d   = length;
               state_d = RUN;
            end
         end
         RUN, DRAIN: begin
            if (abort) begin
               state_d  = IDLE;
               rem_d    = '0;
               occ_d    = 2'd0;
               inf_d    = 1'b0;
               rd_ptr_d = 1'b0;
               wr_ptr_d = 1'b0;
            end else if ((rem_d == '0) && (occ_d == 2'd0) && !inf_d) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else if (rem_d == '0) begin
               state_d = DRAIN;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         rem_q    <= '0;
         occ_q    <= 2'd0;
         inf_q    <= 1'b0;
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         done_q   <= 1'b0;
         mem_q[0] <= '0;
         mem_q[1] <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         rem_q    <= rem_d;
         occ_q    <= occ_d;
         inf_q    <= inf_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         done_q   <= done_d;
         if (push) begin
            mem_q[wr_ptr_q] <= ram_dout;
         end
      end
   end

   assign ram_addr  = addr_q;
   assign ram_wr    = 1'b0;
   assign ram_din   = '0;
   assign out_valid = (occ_q != 2'd0);
   assign out_data  = mem_q[rd_ptr_q];
   assign busy      = (state_q != IDLE);
   assign done      = done_q;

endmodule

`default_nettype wire
